// File: rtl/if_id_stage_if.sv
// Fetch-stage bus: PC-source/hazard/memory inputs into the stage and its
// PC, IF/ID and counter outputs. The stage itself uses the slave modport.
interface if_id_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic [ADDR_W-1:0]  pc_next_i;
    logic               pc_write_i;
    logic               ifid_write_i;
    logic               flush_i;
    logic [INSTR_W-1:0] instr_i;
    logic [ADDR_W-1:0]  pc_o;
    logic [ADDR_W-1:0]  pc_plus4_o;
    logic [ADDR_W-1:0]  ifid_pc_plus4_o;
    logic [INSTR_W-1:0] ifid_instr_o;
    logic               ifid_valid_o;
    logic [CNT_W-1:0]   stall_cnt_o;
    logic [CNT_W-1:0]   flush_cnt_o;

    modport master (
        output pc_next_i, pc_write_i, ifid_write_i, flush_i, instr_i,
        input  pc_o, pc_plus4_o, ifid_pc_plus4_o, ifid_instr_o, ifid_valid_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  pc_next_i, pc_write_i, ifid_write_i, flush_i, instr_i,
        output pc_o, pc_plus4_o, ifid_pc_plus4_o, ifid_instr_o, ifid_valid_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage: PC register, IF/ID pipeline register with stall/flush, and
// saturating stall/flush performance counters.
module if_id_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input logic           clk_i,
    input logic           rst_i,
    if_id_stage_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  ifid_pc_plus4_q;
    logic [INSTR_W-1:0] ifid_instr_q;
    logic               ifid_valid_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   flush_cnt_q;
    logic               stall_evt;

    // Carry out of bit ADDR_W-1 is dropped, so the top word wraps to zero.
    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign stall_evt = (!bus.pc_write_i || !bus.ifid_write_i) && !bus.flush_i;

    // NOTE: every register below uses non-blocking assignment so all state
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else if (bus.pc_write_i) begin
            pc_q <= {bus.pc_next_i[ADDR_W-1:2], 2'b00};
        end
    end

    // Flush outranks the write-enable so a squash still lands during a stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifid_pc_plus4_q <= '0;
            ifid_instr_q    <= '0;
            ifid_valid_q    <= 1'b0;
        end else if (bus.flush_i) begin
            ifid_pc_plus4_q <= '0;
            ifid_instr_q    <= '0;
            ifid_valid_q    <= 1'b0;
        end else if (bus.ifid_write_i) begin
            ifid_pc_plus4_q <= pc_plus4;
            ifid_instr_q    <= bus.instr_i;
            ifid_valid_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (bus.flush_i && flush_cnt_q != CNT_MAX) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_o            = pc_q;
    assign bus.pc_plus4_o      = pc_plus4;
    assign bus.ifid_pc_plus4_o = ifid_pc_plus4_q;
    assign bus.ifid_instr_o    = ifid_instr_q;
    assign bus.ifid_valid_o    = ifid_valid_q;
    assign bus.stall_cnt_o     = stall_cnt_q;
    assign bus.flush_cnt_o     = flush_cnt_q;
endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver queues hand-computed state,
// the monitor compares it after each edge (or on demand for async reset).
module tb_if_id_stage;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        pw = 1'b1, iw = 1'b1, fl = 1'b0, loop_next = 1'b1;
    logic [31:0] manual_next = '0;

    always #5 clk_i = ~clk_i;

    if_id_stage_if #(.CNT_W(16)) bus_a ();
    if_id_stage_if #(.CNT_W(4))  bus_b ();

    // Both stages see identical controls; instruction memory returns the PC.
    assign bus_a.pc_write_i   = pw;
    assign bus_a.ifid_write_i = iw;
    assign bus_a.flush_i      = fl;
    assign bus_a.pc_next_i    = loop_next ? bus_a.pc_plus4_o : manual_next;
    assign bus_a.instr_i      = bus_a.pc_o;
    assign bus_b.pc_write_i   = pw;
    assign bus_b.ifid_write_i = iw;
    assign bus_b.flush_i      = fl;
    assign bus_b.pc_next_i    = loop_next ? bus_b.pc_plus4_o : manual_next;
    assign bus_b.instr_i      = bus_b.pc_o;

    if_id_stage #(.CNT_W(16)) u_dut_a (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_a));
    if_id_stage #(.CNT_W(4))  u_dut_b (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_b));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ifid_p4;
        logic [31:0] ifid_instr;
        logic        valid;
        logic [15:0] stall;
        logic [15:0] flush;
        logic [3:0]  stall_sat;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    event check_now;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] ip4, input logic [31:0] iinstr,
                        input logic v, input logic [15:0] st, input logic [15:0] fc,
                        input logic [3:0] sat);
        exp_t e;
        e.pc = pc; e.pc4 = pc4; e.ifid_p4 = ip4; e.ifid_instr = iinstr;
        e.valid = v; e.stall = st; e.flush = fc; e.stall_sat = sat;
        sb_q.push_back(e);
    endtask

    // Called at a falling edge: drive controls, queue the post-edge state.
    task automatic step(input logic pw_v, input logic iw_v, input logic fl_v,
                        input logic lp, input logic [31:0] nxt,
                        input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] ip4, input logic [31:0] iinstr,
                        input logic v, input logic [15:0] st, input logic [15:0] fc,
                        input logic [3:0] sat);
        pw = pw_v; iw = iw_v; fl = fl_v; loop_next = lp; manual_next = nxt;
        push(pc, pc4, ip4, iinstr, v, st, fc, sat);
        @(negedge clk_i);
    endtask

    task automatic async_check(input logic [31:0] pc);
        #1;
        push(pc, pc + 32'd4, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0, 4'h0);
        ->check_now;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i or check_now);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("pc",         bus_a.pc_o,            e.pc);
                check("pc_plus4",   bus_a.pc_plus4_o,      e.pc4);
                check("ifid_pc4",   bus_a.ifid_pc_plus4_o, e.ifid_p4);
                check("ifid_instr", bus_a.ifid_instr_o,    e.ifid_instr);
                check("ifid_valid", 32'(bus_a.ifid_valid_o), 32'(e.valid));
                check("stall_cnt",  32'(bus_a.stall_cnt_o),  32'(e.stall));
                check("flush_cnt",  32'(bus_a.flush_cnt_o),  32'(e.flush));
                check("stall_sat",  32'(bus_b.stall_cnt_o),  32'(e.stall_sat));
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        // Reset state, checked while reset is held.
        async_check(32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Free-run: PC 0,4,8,C,10 with instr == PC.
        step(1,1,0,1,0, 32'h4,  32'h8,  32'h4,  32'h0, 1, 0, 0, 0);
        step(1,1,0,1,0, 32'h8,  32'hC,  32'h8,  32'h4, 1, 0, 0, 0);
        step(1,1,0,1,0, 32'hC,  32'h10, 32'hC,  32'h8, 1, 0, 0, 0);
        step(1,1,0,1,0, 32'h10, 32'h14, 32'h10, 32'hC, 1, 0, 0, 0);

        // Three-cycle stall at PC=0x10, then release.
        for (int k = 1; k <= 3; k++)
            step(0,0,0,1,0, 32'h10, 32'h14, 32'h10, 32'hC, 1, 16'(k), 0, 4'(k));
        step(1,1,0,1,0, 32'h14, 32'h18, 32'h14, 32'h10, 1, 3, 0, 3);

        // Flush during IF/ID stall redirects PC and squashes.
        step(1,0,1,0,32'h40, 32'h40, 32'h44, 32'h0, 32'h0, 0, 3, 1, 3);
        // Flush with PC stalled: PC holds, flush counts, stall does not.
        step(0,1,1,0,32'h80, 32'h40, 32'h44, 32'h0, 32'h0, 0, 3, 2, 3);

        // Unaligned target is forced to word alignment; IF/ID held.
        step(1,0,0,0,32'h103, 32'h100, 32'h104, 32'h0, 32'h0, 0, 4, 2, 4);
        step(1,1,0,1,0, 32'h104, 32'h108, 32'h104, 32'h100, 1, 4, 2, 4);

        // Top-of-memory PC: PC+4 wraps to zero.
        step(1,1,0,0,32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h108, 32'h104, 1, 4, 2, 4);
        step(1,1,0,1,0, 32'h0, 32'h4, 32'h0, 32'hFFFF_FFFC, 1, 4, 2, 4);

        // Long stall: the 4-bit counter sticks at 15.
        for (int k = 1; k <= 20; k++)
            step(0,0,0,1,0, 32'h0, 32'h4, 32'h0, 32'hFFFF_FFFC, 1, 16'(4 + k), 2,
                 (4 + k > 15) ? 4'd15 : 4'(4 + k));
        step(1,1,0,1,0, 32'h4, 32'h8, 32'h4, 32'h0, 1, 24, 2, 15);

        // Asynchronous reset between edges while IF/ID is valid.
        #2;
        rst_i = 1'b1;
        async_check(32'h0);
        @(negedge clk_i);
        step(1,1,1,0,32'h20, 32'h0, 32'h4, 32'h0, 32'h0, 0, 0, 0, 0);
        rst_i = 1'b0;
        step(1,1,0,1,0, 32'h4, 32'h8, 32'h4, 32'h0, 1, 0, 0, 0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk_i);
        #2;
        if (sb_q.size() != 0) check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
